// File: rtl/id_hazard_stage.sv
// id_hazard_stage: IF/ID pipeline register plus ID-stage branch/jump
// resolution and hazard detection for the 5-stage MIPS core.
// Latency: outputs are combinational from IF/ID state and same-cycle inputs.
// Backpressure: stall holds IF/ID and fetch; pc_sel redirects fetch and squashes.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   instruction_code, pipl_pc    instruction and its PC+4 from fetch
//   rs_data, rt_data             register-file read data for rs_addr/rt_addr
//   ex_reg_write, ex_mem_read,
//   ex_dst                       EX-stage instruction info for hazards
//   mem_mem_read, mem_dst        MEM-stage load info for branch hazards
//   stall, pc_sel, pc_pip        fetch control: hold / redirect / target
//   rs_addr, rt_addr             register-file read addresses
//   ex_instr, ex_pc_plus4,
//   ex_valid                     instruction issued to EX (0 valid = bubble)
// Optional: define ID_PERF_CNT_EN to add stall_count / flush_count outputs.
module id_hazard_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction_code,
  input  logic [31:0] pipl_pc,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_dst,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_dst,
  output logic        stall,
  output logic        pc_sel,
  output logic [31:0] pc_pip,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [31:0] ex_instr,
  output logic [31:0] ex_pc_plus4,
  output logic        ex_valid
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // IF/ID register
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q,   id_pc4_d;
  logic        id_valid_q, id_valid_d;

  logic [5:0]  opcode;
  logic        is_beq, is_bne, is_branch, is_jump;
  logic        uses_rs, uses_rt;
  logic        load_use_haz, br_alu_haz, br_mem_haz;
  logic        taken;
  logic [31:0] br_target, j_target;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] d, input logic [4:0] r);
    return (d != 5'd0) && (d == r);
  endfunction

  assign opcode    = id_instr_q[31:26];
  assign rs_addr   = id_instr_q[25:21];
  assign rt_addr   = id_instr_q[20:16];

  assign is_beq    = (opcode == OP_BEQ);
  assign is_bne    = (opcode == OP_BNE);
  assign is_branch = is_beq | is_bne;
  assign is_jump   = (opcode == OP_J) | (opcode == OP_JAL);
  assign uses_rs   = !(is_jump | (opcode == OP_LUI));
  assign uses_rt   = (opcode == OP_RTYPE) | is_branch | (opcode == OP_SW);

  assign load_use_haz = ex_mem_read &
                        ((uses_rs & reg_match(ex_dst, rs_addr)) |
                         (uses_rt & reg_match(ex_dst, rt_addr)));
  // Branches compare in ID, so any producer still in EX must be waited on;
  // a load in MEM has no data yet either, giving the second stall cycle.
  assign br_alu_haz   = is_branch & ex_reg_write &
                        (reg_match(ex_dst, rs_addr) | reg_match(ex_dst, rt_addr));
  assign br_mem_haz   = is_branch & mem_mem_read &
                        (reg_match(mem_dst, rs_addr) | reg_match(mem_dst, rt_addr));

  assign stall = id_valid_q & (load_use_haz | br_alu_haz | br_mem_haz);

  assign taken = (is_beq & (rs_data == rt_data)) |
                 (is_bne & (rs_data != rt_data)) |
                 is_jump;

  assign pc_sel = id_valid_q & !stall & taken;

  assign br_target = id_pc4_q + {{14{id_instr_q[15]}}, id_instr_q[15:0], 2'b00};
  assign j_target  = {id_pc4_q[31:28], id_instr_q[25:0], 2'b00};
  assign pc_pip    = is_jump ? j_target : br_target;

  assign ex_instr    = id_instr_q;
  assign ex_pc_plus4 = id_pc4_q;
  assign ex_valid    = id_valid_q & !stall;

  always_comb begin
    id_instr_d = id_instr_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;
    if (stall) begin
      // hold all fields
    end else if (pc_sel) begin
      // squash the sequential-path instruction (no delay slot)
      id_valid_d = 1'b0;
      id_instr_d = 32'd0;
    end else begin
      id_instr_d = instruction_code;
      id_pc4_d   = pipl_pc;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_instr_q <= 32'd0;
      id_pc4_q   <= 32'd0;
      id_valid_q <= 1'b0;
    end else begin
      id_instr_q <= id_instr_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
    end
  end

`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  assign stall_cnt_d = stall_cnt_q + {31'd0, stall};
  assign flush_cnt_d = flush_cnt_q + {31'd0, pc_sel};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_hazard_stage.sv
// tb_id_hazard_stage: directed scenarios plus randomized traffic for
// id_hazard_stage, compared against an instruction-level reference model.
// Inputs change half a cycle before the sampling edge; outputs checked 1ns later.
module tb_id_hazard_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction_code = '0;
  logic [31:0] pipl_pc = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        ex_reg_write = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic [4:0]  ex_dst = '0;
  logic        mem_mem_read = 1'b0;
  logic [4:0]  mem_dst = '0;
  logic        stall, pc_sel, ex_valid;
  logic [31:0] pc_pip, ex_instr, ex_pc_plus4;
  logic [4:0]  rs_addr, rt_addr;
`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_count, flush_count;
`endif

  id_hazard_stage dut (
    .clock(clock), .reset(reset),
    .instruction_code(instruction_code), .pipl_pc(pipl_pc),
    .rs_data(rs_data), .rt_data(rt_data),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
    .mem_mem_read(mem_mem_read), .mem_dst(mem_dst),
    .stall(stall), .pc_sel(pc_sel), .pc_pip(pc_pip),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .ex_instr(ex_instr), .ex_pc_plus4(ex_pc_plus4), .ex_valid(ex_valid)
`ifdef ID_PERF_CNT_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model: the instruction sitting in ID and expected outputs.
  logic [31:0] m_instr = '0, m_pc4 = '0;
  bit          m_valid = 0;
  bit          e_stall, e_sel;
  logic [31:0] e_pip;
  int unsigned e_stall_cnt = 0, e_flush_cnt = 0;

  function automatic bit dep(input logic [4:0] d, input logic [4:0] r);
    return (d != 0) && (d == r);
  endfunction

  task automatic ref_eval();
    logic [5:0] op;
    logic [4:0] rs, rt;
    bit br, jmp, urs, urt, haz, tk;
    logic signed [31:0] off;
    op  = m_instr[31:26];
    rs  = m_instr[25:21];
    rt  = m_instr[20:16];
    br  = (op == 6'd4) || (op == 6'd5);
    jmp = (op == 6'd2) || (op == 6'd3);
    urs = !(jmp || op == 6'd15);
    urt = op inside {6'd0, 6'd4, 6'd5, 6'd43};
    haz = (ex_mem_read && ((urs && dep(ex_dst, rs)) || (urt && dep(ex_dst, rt)))) ||
          (br && ex_reg_write && (dep(ex_dst, rs) || dep(ex_dst, rt))) ||
          (br && mem_mem_read && (dep(mem_dst, rs) || dep(mem_dst, rt)));
    e_stall = m_valid && haz;
    tk = jmp || (op == 6'd4 && rs_data == rt_data) || (op == 6'd5 && rs_data != rt_data);
    e_sel = m_valid && !e_stall && tk;
    off = $signed({{16{m_instr[15]}}, m_instr[15:0]});
    if (jmp) e_pip = (m_pc4 & 32'hF000_0000) | (m_instr[25:0] * 4);
    else     e_pip = m_pc4 + off * 4;
  endtask

  task automatic check_outs(input string pfx);
    ref_eval();
    chk({pfx, ".stall"}, {31'd0, stall}, {31'd0, e_stall});
    chk({pfx, ".pc_sel"}, {31'd0, pc_sel}, {31'd0, e_sel});
    chk({pfx, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, m_valid && !e_stall});
    chk({pfx, ".ex_instr"}, ex_instr, m_instr);
    chk({pfx, ".ex_pc4"}, ex_pc_plus4, m_pc4);
    chk({pfx, ".rs_addr"}, {27'd0, rs_addr}, {27'd0, m_instr[25:21]});
    chk({pfx, ".rt_addr"}, {27'd0, rt_addr}, {27'd0, m_instr[20:16]});
    if (e_sel) chk({pfx, ".pc_pip"}, pc_pip, e_pip);
  endtask

  // Called at a negedge with inputs already set: check, clock, update model.
  task automatic step(input string pfx);
    #1;
    check_outs(pfx);
    @(posedge clock);
    if (e_stall) e_stall_cnt++;
    if (e_sel) e_flush_cnt++;
    if (e_stall) begin
    end else if (e_sel) begin
      m_valid = 0;
      m_instr = '0;
    end else begin
      m_valid = 1;
      m_instr = instruction_code;
      m_pc4   = pipl_pc;
    end
    @(negedge clock);
  endtask

  task automatic clear_haz();
    ex_reg_write = 0; ex_mem_read = 0; ex_dst = 0;
    mem_mem_read = 0; mem_dst = 0;
  endtask

  task automatic model_reset();
    m_instr = '0; m_pc4 = '0; m_valid = 0;
    e_stall_cnt = 0; e_flush_cnt = 0;
  endtask

  // Place an instruction into ID; bounded in case a redirect squashes it.
  task automatic load(input logic [31:0] instr, input logic [31:0] pc);
    clear_haz();
    rs_data = 32'd1; rt_data = 32'd2;
    instruction_code = instr;
    pipl_pc = pc;
    for (int i = 0; i < 4; i++) begin
      step("load");
      if (m_valid && m_instr == instr && m_pc4 == pc) break;
    end
    #1;
    chk("load.ex_instr", ex_instr, instr);
    instruction_code = 32'h0000_0020;
  endtask

  logic [5:0] ops [9] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd15, 6'd35, 6'd43, 6'd8};

  initial begin
    // Reset state
    #1;
    chk("rst.stall", {31'd0, stall}, 32'd0);
    chk("rst.pc_sel", {31'd0, pc_sel}, 32'd0);
    chk("rst.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst.ex_instr", ex_instr, 32'd0);
    chk("rst.ex_pc4", ex_pc_plus4, 32'd0);
    @(negedge clock);
    reset = 0;
    step("idle");

    // Reset mid-stall drops stall immediately, then first capture
    load(32'h0109_4020, 32'h80);
    ex_mem_read = 1; ex_dst = 5'd8;
    #1;
    chk("rstmid.stall_before", {31'd0, stall}, 32'd1);
    reset = 1;
    #1;
    chk("rstmid.stall", {31'd0, stall}, 32'd0);
    chk("rstmid.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rstmid.ex_instr", ex_instr, 32'd0);
    chk("rstmid.ex_pc4", ex_pc_plus4, 32'd0);
    model_reset();
    @(negedge clock);
    reset = 0;
    clear_haz();
    instruction_code = 32'h2008_0005; pipl_pc = 32'd4;
    step("rst_rel");
    #1;
    chk("rst_rel.ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("rst_rel.ex_instr", ex_instr, 32'h2008_0005);
    chk("rst_rel.ex_pc4", ex_pc_plus4, 32'd4);

    // Taken / not-taken BEQ
    load(32'h1085_0003, 32'h100);
    rs_data = 7; rt_data = 8;
    #1;
    chk("beq_nt.pc_sel", {31'd0, pc_sel}, 32'd0);
    rt_data = 7;
    #1;
    chk("beq.pc_sel", {31'd0, pc_sel}, 32'd1);
    chk("beq.pc_pip", pc_pip, 32'h10C);
    step("beq");
    #1;
    chk("beq.squash", {31'd0, ex_valid}, 32'd0);

    // Load-use: one stall cycle, IF/ID held
    load(32'h0109_4020, 32'h200);
    ex_mem_read = 1; ex_dst = 5'd8;
    #1;
    chk("lu.stall", {31'd0, stall}, 32'd1);
    chk("lu.ex_valid", {31'd0, ex_valid}, 32'd0);
    step("lu");
    clear_haz();
    #1;
    chk("lu.release", {31'd0, stall}, 32'd0);
    chk("lu.held_instr", ex_instr, 32'h0109_4020);
    chk("lu.held_pc4", ex_pc_plus4, 32'h200);
    chk("lu.issue", {31'd0, ex_valid}, 32'd1);
    step("lu2");

    // Branch directly after a load: two stall cycles then redirect
    load(32'h1109_0002, 32'h300);
    rs_data = 5; rt_data = 5;
    ex_mem_read = 1; ex_reg_write = 1; ex_dst = 5'd8;
    #1;
    chk("bal.stall1", {31'd0, stall}, 32'd1);
    step("bal1");
    clear_haz();
    mem_mem_read = 1; mem_dst = 5'd8;
    #1;
    chk("bal.stall2", {31'd0, stall}, 32'd1);
    step("bal2");
    clear_haz();
    #1;
    chk("bal.stall3", {31'd0, stall}, 32'd0);
    chk("bal.pc_sel", {31'd0, pc_sel}, 32'd1);
    chk("bal.pc_pip", pc_pip, 32'h308);
    step("bal3");

    // Destination $0 never stalls
    load(32'h1109_0002, 32'h400);
    ex_mem_read = 1; ex_reg_write = 1; ex_dst = 5'd0;
    #1;
    chk("dst0.stall", {31'd0, stall}, 32'd0);
    step("dst0");

    // JAL
    load(32'h0C00_0040, 32'h4000_0010);
    #1;
    chk("jal.pc_pip", pc_pip, 32'h4000_0100);
    chk("jal.pc_sel", {31'd0, pc_sel}, 32'd1);
    chk("jal.ex_pc4", ex_pc_plus4, 32'h4000_0010);
    step("jal");

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 8)];
      ins[25:21] = 5'($urandom_range(0, 5));
      ins[20:16] = 5'($urandom_range(0, 5));
      instruction_code = ins;
      pipl_pc = $urandom & 32'hFFFF_FFFC;
      rs_data = $urandom_range(0, 3);
      rt_data = $urandom_range(0, 3);
      ex_reg_write = ($urandom_range(0, 2) == 0);
      ex_mem_read  = ($urandom_range(0, 3) == 0);
      ex_dst       = 5'($urandom_range(0, 5));
      mem_mem_read = ($urandom_range(0, 3) == 0);
      mem_dst      = 5'($urandom_range(0, 5));
      step("rnd");
    end
    clear_haz();

`ifdef ID_PERF_CNT_EN
    #1;
    chk("perf.stall_count", stall_count, e_stall_cnt);
    chk("perf.flush_count", flush_count, e_flush_cnt);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
